// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and widths for the PC sequencer
package pc_seq_pkg;

    localparam int PC_ADDR_W = 6;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRZ  = 3'd2,
        OP_BRNZ = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SHADOW = 2'd1,
        HALT   = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// rtl/pc_sequencer_return_stack.sv - return-address LIFO; a push while full discards the oldest entry
module return_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = PC_ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] top
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] topCnt;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign topCnt = count - CNT_W'(1);
    assign top    = empty ? '0 : entries[topCnt[IDX_W-1:0]];

    // Entry 0 is the oldest; a full push shifts everything down one slot.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i + 1];
                entries[DEPTH - 1] <= pushData;
            end else begin
                entries[count[IDX_W-1:0]] <= pushData;
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-address control for ProgramCounter with return stack; optional RAS_TRAP_EN traps stack errors into HALT
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W,
`ifdef RAS_TRAP_EN
    parameter logic [ADDR_W-1:0] TRAP_ADDR = 6'd63,
`endif
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              stall,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] pc_cur,
    output logic              pc_we,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              flush,
    output logic              ras_ovf,
    output logic              ras_unf
);

    state_e            state;
    state_e            nextState;
    logic              pushReq;
    logic              popReq;
    logic              ovfHit;
    logic              unfHit;
    logic              rasFull;
    logic              rasEmpty;
    logic [ADDR_W-1:0] rasTop;
    logic [ADDR_W-1:0] retAddr;

    assign retAddr = pc_cur + ADDR_W'(1);

    return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .nReset   (nReset),
        .push     (pushReq),
        .pop      (popReq),
        .pushData (retAddr),
        .full     (rasFull),
        .empty    (rasEmpty),
        .top      (rasTop)
    );

    // Next-address mux: hold on stall or HALT, redirect on taken ops, otherwise let the PC increment.
    always_comb begin
        pc_we     = 1'b0;
        pc_addr   = '0;
        nextState = state;
        pushReq   = 1'b0;
        popReq    = 1'b0;
        ovfHit    = 1'b0;
        unfHit    = 1'b0;
        case (state)
            RUN: begin
                if (stall) begin
                    pc_we   = 1'b1;
                    pc_addr = pc_cur;
                end else begin
                    case (op)
                        OP_JMP: begin
                            pc_we = 1'b1; pc_addr = target; nextState = SHADOW;
                        end
                        OP_BRZ: if (zero_flag) begin
                            pc_we = 1'b1; pc_addr = target; nextState = SHADOW;
                        end
                        OP_BRNZ: if (!zero_flag) begin
                            pc_we = 1'b1; pc_addr = target; nextState = SHADOW;
                        end
                        OP_CALL: begin
                            ovfHit = rasFull;
                            pc_we  = 1'b1;
`ifdef RAS_TRAP_EN
                            if (rasFull) begin
                                pc_addr = TRAP_ADDR; nextState = HALT;
                            end else begin
                                pushReq = 1'b1; pc_addr = target; nextState = SHADOW;
                            end
`else
                            pushReq   = 1'b1;
                            pc_addr   = target;
                            nextState = SHADOW;
`endif
                        end
                        OP_RET: begin
                            unfHit = rasEmpty;
                            pc_we  = 1'b1;
`ifdef RAS_TRAP_EN
                            if (rasEmpty) begin
                                pc_addr = TRAP_ADDR; nextState = HALT;
                            end else begin
                                popReq = 1'b1; pc_addr = rasTop; nextState = SHADOW;
                            end
`else
                            // An empty stack reads as address 0, which is the underflow target.
                            popReq    = !rasEmpty;
                            pc_addr   = rasTop;
                            nextState = SHADOW;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            SHADOW: begin
                if (stall) begin
                    pc_we   = 1'b1;
                    pc_addr = pc_cur;
                end else begin
                    nextState = RUN;
                end
            end
            HALT: begin
                pc_we   = 1'b1;
                pc_addr = pc_cur;
            end
            default: nextState = RUN;
        endcase
        if (!nReset) begin
            pc_we   = 1'b0;
            pc_addr = '0;
        end
    end

    // State, flush pulse and sticky stack error flags.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state   <= RUN;
            flush   <= 1'b0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            state <= nextState;
            flush <= (nextState == SHADOW) || (nextState == HALT && state != HALT);
            if (ovfHit) ras_ovf <= 1'b1;
            if (unfHit) ras_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] op = 3'd0;
    logic [5:0] target = '0;
    logic       zero_flag = 1'b0;
    logic [5:0] pc_cur = '0;
    logic       pc_we;
    logic [5:0] pc_addr;
    logic       flush;
    logic       ras_ovf;
    logic       ras_unf;

    int nChecks = 0;
    int nFails = 0;

    // Model state: program counter, return addresses, and mode flags
    logic [5:0] pcm = '0;
    logic [5:0] ras [$];
    logic       inShadow = 1'b0;
    logic       halted = 1'b0;
    logic       eFlush = 1'b0;
    logic       mOvf = 1'b0;
    logic       mUnf = 1'b0;

    pc_sequencer #(.ADDR_W(6), .RAS_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .stall     (stall),
        .op        (op),
        .target    (target),
        .zero_flag (zero_flag),
        .pc_cur    (pc_cur),
        .pc_we     (pc_we),
        .pc_addr   (pc_addr),
        .flush     (flush),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic doReset();
        #2 nReset = 1'b0;
        #1;
        check("rst_pc_we", pc_we, 0);
        check("rst_pc_addr", pc_addr, 0);
        check("rst_flush", flush, 0);
        check("rst_ovf", ras_ovf, 0);
        check("rst_unf", ras_unf, 0);
        pcm = '0; pc_cur = '0;
        ras.delete();
        inShadow = 0; halted = 0; eFlush = 0; mOvf = 0; mUnf = 0;
        @(posedge clk);
        #1 nReset = 1'b1;
    endtask

    task automatic step(input logic s, input logic [2:0] o, input logic [5:0] t, input logic z);
        logic       eWe;
        logic [5:0] eAddr;
        logic       goShadow;
        logic       goHalt;
        logic       ovfP;
        logic       unfP;
        logic       redirect;
        stall = s; op = o; target = t; zero_flag = z; pc_cur = pcm;
        @(negedge clk);
        eWe = 0; eAddr = '0; goShadow = 0; goHalt = 0; ovfP = 0; unfP = 0; redirect = 0;
        if (halted || inShadow || s) begin
            if (halted || s) begin eWe = 1; eAddr = pcm; end
        end else begin
            case (o)
                3'd1: redirect = 1;
                3'd2: redirect = z;
                3'd3: redirect = !z;
                3'd4: begin
                    if (ras.size() == DEPTH) begin
                        ovfP = 1;
`ifdef RAS_TRAP_EN
                        eWe = 1; eAddr = 6'd63; goHalt = 1;
`else
                        ras.delete(0);
                        ras.push_back(6'(pcm + 1));
                        redirect = 1;
`endif
                    end else begin
                        ras.push_back(6'(pcm + 1));
                        redirect = 1;
                    end
                end
                3'd5: begin
                    if (ras.size() == 0) begin
                        unfP = 1;
`ifdef RAS_TRAP_EN
                        eWe = 1; eAddr = 6'd63; goHalt = 1;
`else
                        eWe = 1; eAddr = 6'd0; goShadow = 1;
`endif
                    end else begin
                        eWe = 1; eAddr = ras.pop_back(); goShadow = 1;
                    end
                end
                default: ;
            endcase
            if (redirect) begin eWe = 1; eAddr = t; goShadow = 1; end
        end
        check("pc_we", pc_we, eWe);
        if (eWe) check("pc_addr", pc_addr, eAddr);
        check("flush", flush, eFlush);
        check("ras_ovf", ras_ovf, mOvf);
        check("ras_unf", ras_unf, mUnf);
        @(posedge clk);
        #1;
        pcm      = eWe ? eAddr : 6'(pcm + 1);
        eFlush   = goShadow || goHalt || (inShadow && s);
        inShadow = goShadow || (inShadow && s);
        halted   = halted || goHalt;
        mOvf     = mOvf || ovfP;
        mUnf     = mUnf || unfP;
    endtask

    initial begin
        doReset();
        // Free-run, then jump from 5 to 40
        for (int i = 0; i < 5; i++) step(0, 3'd0, 6'd0, 0);
        step(0, 3'd1, 6'd40, 0);
        for (int i = 0; i < 5; i++) step(0, 3'd0, 6'd0, 0);
        // Branches not taken and taken
        step(0, 3'd2, 6'd20, 0);
        step(0, 3'd3, 6'd20, 1);
        step(0, 3'd2, 6'd20, 1);
        step(0, 3'd0, 6'd0, 0);
        step(0, 3'd3, 6'd25, 0);
        step(0, 3'd0, 6'd0, 0);
        // Nested call and return: 9 -> shadow -> CALL at 10, CALL at 31
        step(0, 3'd1, 6'd9, 0);
        step(0, 3'd0, 6'd0, 0);
        step(0, 3'd4, 6'd30, 0);
        step(0, 3'd0, 6'd0, 0);
        step(0, 3'd4, 6'd50, 0);
        step(0, 3'd0, 6'd0, 0);
        step(0, 3'd5, 6'd0, 0);
        step(0, 3'd0, 6'd0, 0);
        step(0, 3'd5, 6'd0, 0);
        step(0, 3'd0, 6'd0, 0);
        // Stalled jump, including stall in the shadow
        for (int i = 0; i < 3; i++) step(1, 3'd1, 6'd17, 0);
        step(0, 3'd1, 6'd17, 0);
        step(1, 3'd0, 6'd0, 0);
        step(0, 3'd0, 6'd0, 0);
        // Return from 63 wraps the pushed address to 0
        step(0, 3'd1, 6'd62, 0);
        step(0, 3'd0, 6'd0, 0);
        step(0, 3'd4, 6'd5, 0);
        step(0, 3'd0, 6'd0, 0);
        step(0, 3'd5, 6'd0, 0);
        step(0, 3'd0, 6'd0, 0);
        // Overflow then underflow
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(0, 3'd4, 6'(8 * i + 3), 0);
            step(0, 3'd0, 6'd0, 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(0, 3'd5, 6'd0, 0);
            step(0, 3'd0, 6'd0, 0);
        end
        step(0, 3'd1, 6'd2, 0);
        doReset();
        step(0, 3'd5, 6'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 3'd0, 6'd0, 0);
        doReset();
        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 79) == 0) doReset();
            else step($urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)), 6'($urandom), 1'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
